load_use_scoreboard: RTL and testbench



---
 rtl/load_use_scoreboard.sv | 103 ++++++++++
 tb/tb_load_use_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit at the decode/execute boundary.
// A per-register scoreboard tracks loads that have left EX but whose data
// cannot yet be forwarded. A decode operand that hits either the load in EX
// or a pending scoreboard entry freezes PC and IF/ID and sends a bubble into
// ID/EX. A saturating counter records how many cycles were lost to stalls.
module load_use_scoreboard #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          exec_mr,
  input  logic                          exec_jwsp,
  input  logic [REG_ADDR_W-1:0]         exec_dst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_src,
  input  logic [NUM_SRC-1:0]            dec_src_vld,
  input  logic                          dec_flush,
  output logic                          keep_pc,
  output logic                          keep_fetched_instruction,
  output logic                          flush_mux_selector,
  output logic                          pending,
  output logic [CNT_W-1:0]              stall_count
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  // Each entry must hold LOAD_LAT-1; a 1-bit entry is kept even when
  // LOAD_LAT=1 so the array always has a legal width (it then stays zero).
  localparam int SB_W = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
  localparam logic [SB_W-1:0]  SB_RELOAD = SB_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SB_W-1:0]       r_cnt [NUM_REGS];
  logic [CNT_W-1:0]      r_stallCount;
  logic                  w_execLoad;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_pending;
  logic [REG_ADDR_W-1:0] w_srcAddr;

  // A stack-pop jump reads memory but writes no GPR, so it never feeds a consumer.
  assign w_execLoad = exec_mr & ~exec_jwsp;

  // Same-cycle hazard check: each qualified source against the EX load and the scoreboard.
  always_comb begin
    w_hazard  = 1'b0;
    w_srcAddr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_srcAddr = dec_src[i*REG_ADDR_W +: REG_ADDR_W];
      if (dec_src_vld[i] &&
          ((w_execLoad && (exec_dst == w_srcAddr)) || (r_cnt[w_srcAddr] != '0))) begin
        w_hazard = 1'b1;
      end
    end
  end

  // A killed decode instruction has no operands worth waiting for.
  assign w_stall = w_hazard & ~dec_flush;

  // Summarise the scoreboard; derived only from registered entries.
  always_comb begin
    w_pending = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r_cnt[r] != '0) begin
        w_pending = 1'b1;
      end
    end
  end

  // Scoreboard: loads in flight age every cycle regardless of stalls; the youngest load to a register restarts its entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if ((LOAD_LAT > 1) && w_execLoad && (exec_dst == REG_ADDR_W'(r))) begin
          r_cnt[r] <= SB_RELOAD;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  // Saturating performance counter of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (w_stall && (r_stallCount != CNT_MAX)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign keep_pc                  = w_stall;
  assign keep_fetched_instruction = w_stall;
  assign flush_mux_selector       = w_stall;
  assign pending                  = w_pending;
  assign stall_count              = r_stallCount;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard. Two instances share one stimulus
// bus: lat1Dut (LOAD_LAT=1, CNT_W=4) covers the EX-only compare and counter
// saturation, lat3Dut (LOAD_LAT=3, CNT_W=16) covers the scoreboard behaviour.
module tb_load_use_scoreboard;

   logic       clk;
   logic       rst;
   logic       execMr;
   logic       execJwsp;
   logic [2:0] execDst;
   logic [5:0] decSrc;
   logic [1:0] decSrcVld;
   logic       decFlush;

   logic        lat1KeepPc, lat1KeepFi, lat1FlushSel, lat1Pending;
   logic [3:0]  lat1Count;
   logic        lat3KeepPc, lat3KeepFi, lat3FlushSel, lat3Pending;
   logic [15:0] lat3Count;

   logic [2:0] lat1Stall;
   logic [2:0] lat3Stall;

   int checks = 0;
   int errors = 0;

   assign lat1Stall = {lat1KeepPc, lat1KeepFi, lat1FlushSel};
   assign lat3Stall = {lat3KeepPc, lat3KeepFi, lat3FlushSel};

   load_use_scoreboard #(
      .REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)
   ) lat1Dut (
      .clk(clk), .rst(rst),
      .exec_mr(execMr), .exec_jwsp(execJwsp), .exec_dst(execDst),
      .dec_src(decSrc), .dec_src_vld(decSrcVld), .dec_flush(decFlush),
      .keep_pc(lat1KeepPc), .keep_fetched_instruction(lat1KeepFi),
      .flush_mux_selector(lat1FlushSel), .pending(lat1Pending),
      .stall_count(lat1Count)
   );

   load_use_scoreboard #(
      .REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)
   ) lat3Dut (
      .clk(clk), .rst(rst),
      .exec_mr(execMr), .exec_jwsp(execJwsp), .exec_dst(execDst),
      .dec_src(decSrc), .dec_src_vld(decSrcVld), .dec_flush(decFlush),
      .keep_pc(lat3KeepPc), .keep_fetched_instruction(lat3KeepFi),
      .flush_mux_selector(lat3FlushSel), .pending(lat3Pending),
      .stall_count(lat3Count)
   );

   // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one decode/EX cycle on the falling edge, then let the combinational outputs settle.
   task automatic applyStimulus(input logic iRst, input logic iMr, input logic iJwsp,
                                input logic [2:0] iDst, input logic [2:0] iSrc0,
                                input logic [2:0] iSrc1, input logic [1:0] iVld,
                                input logic iFlush);
      @(negedge clk);
      rst       = iRst;
      execMr    = iMr;
      execJwsp  = iJwsp;
      execDst   = iDst;
      decSrc    = {iSrc1, iSrc0};
      decSrcVld = iVld;
      decFlush  = iFlush;
      #1;
   endtask

   // One comparison: count it, and on mismatch count the failure and report it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence; every expected value below is worked out by hand from the cycle plan.
   initial begin
      rst = 1'b1; execMr = 1'b0; execJwsp = 1'b0; execDst = '0;
      decSrc = '0; decSrcVld = '0; decFlush = 1'b0;

      // Reset state.
      applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      checkOutput("rst_lat1_count",   32'(lat1Count),   32'd0);
      checkOutput("rst_lat3_count",   32'(lat3Count),   32'd0);
      checkOutput("rst_lat3_pending", 32'(lat3Pending), 32'd0);
      checkOutput("rst_lat1_stall",   32'(lat1Stall),   32'd0);

      // LOAD_LAT=1: load r3 in EX, decode reads r3 -> one stall cycle.
      applyStimulus(0, 1, 0, 3, 3, 0, 2'b01, 0);
      checkOutput("l1_stall",   32'(lat1Stall),   32'b111);
      checkOutput("l1_pending", 32'(lat1Pending), 32'd0);
      checkOutput("l1_count0",  32'(lat1Count),   32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      checkOutput("l1_count1",  32'(lat1Count),   32'd1);
      checkOutput("l1_release", 32'(lat1Stall),   32'b000);
      checkOutput("l1_pending2", 32'(lat1Pending), 32'd0);

      // Stack-pop jump is never a hazard source.
      applyStimulus(0, 1, 1, 3, 3, 0, 2'b01, 0);
      checkOutput("l1_jwsp_stall", 32'(lat1Stall), 32'b000);
      // Unqualified sources are masked.
      applyStimulus(0, 1, 0, 3, 3, 0, 2'b00, 0);
      checkOutput("l1_vld0_stall", 32'(lat1Stall), 32'b000);
      checkOutput("l1_jwsp_count", 32'(lat1Count), 32'd1);
      applyStimulus(0, 1, 0, 3, 0, 3, 2'b01, 0);
      checkOutput("l1_src1_masked", 32'(lat1Stall), 32'b000);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      checkOutput("l1_mask_count", 32'(lat1Count), 32'd1);

      // Clear lat3Dut, which picked up r3 loads above.
      applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      checkOutput("rst2_lat3_pending", 32'(lat3Pending), 32'd0);
      checkOutput("rst2_lat3_count",   32'(lat3Count),   32'd0);

      // LOAD_LAT=3: load r5 with its consumer already in decode -> 3 stall cycles.
      applyStimulus(0, 1, 0, 5, 5, 0, 2'b01, 0);
      checkOutput("r5_c0_stall",   32'(lat3Stall),   32'b111);
      checkOutput("r5_c0_pending", 32'(lat3Pending), 32'd0);
      applyStimulus(0, 0, 0, 0, 5, 0, 2'b01, 0);
      checkOutput("r5_c1_stall",   32'(lat3Stall),   32'b111);
      checkOutput("r5_c1_pending", 32'(lat3Pending), 32'd1);
      applyStimulus(0, 0, 0, 0, 5, 0, 2'b01, 0);
      checkOutput("r5_c2_stall",   32'(lat3Stall),   32'b111);
      checkOutput("r5_c2_pending", 32'(lat3Pending), 32'd1);
      applyStimulus(0, 0, 0, 0, 5, 0, 2'b01, 0);
      checkOutput("r5_c3_stall",   32'(lat3Stall),   32'b000);
      checkOutput("r5_c3_pending", 32'(lat3Pending), 32'd0);
      checkOutput("r5_count",      32'(lat3Count),   32'd3);

      // Back-to-back loads to r2 then r4; consumer reads both, waits for r4.
      applyStimulus(0, 1, 0, 2, 0, 0, 2'b00, 0);
      checkOutput("r24_a_stall", 32'(lat3Stall), 32'b000);
      applyStimulus(0, 1, 0, 4, 2, 4, 2'b11, 0);
      checkOutput("r24_b_stall", 32'(lat3Stall), 32'b111);
      applyStimulus(0, 0, 0, 0, 2, 4, 2'b11, 0);
      checkOutput("r24_c_stall", 32'(lat3Stall), 32'b111);
      applyStimulus(0, 0, 0, 0, 2, 4, 2'b11, 0);
      checkOutput("r24_d_stall",   32'(lat3Stall),   32'b111);
      checkOutput("r24_d_pending", 32'(lat3Pending), 32'd1);
      applyStimulus(0, 0, 0, 0, 2, 4, 2'b11, 0);
      checkOutput("r24_e_stall",   32'(lat3Stall),   32'b000);
      checkOutput("r24_e_pending", 32'(lat3Pending), 32'd0);
      checkOutput("r24_count",     32'(lat3Count),   32'd6);

      // Reload r4 while pending: entry restarts at 2, so the consumer stalls twice.
      applyStimulus(0, 1, 0, 4, 0, 0, 2'b00, 0);
      applyStimulus(0, 1, 0, 4, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 0, 4, 0, 2'b01, 0);
      checkOutput("reload_h_stall", 32'(lat3Stall), 32'b111);
      applyStimulus(0, 0, 0, 0, 4, 0, 2'b01, 0);
      checkOutput("reload_i_stall", 32'(lat3Stall), 32'b111);
      applyStimulus(0, 0, 0, 0, 4, 0, 2'b01, 0);
      checkOutput("reload_j_stall", 32'(lat3Stall), 32'b000);
      checkOutput("reload_count",   32'(lat3Count), 32'd8);

      // Flush suppresses the stall but the r1 entry keeps ageing.
      applyStimulus(0, 1, 0, 1, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 2'b01, 1);
      checkOutput("flush_l_stall", 32'(lat3Stall), 32'b000);
      applyStimulus(0, 0, 0, 0, 1, 0, 2'b01, 0);
      checkOutput("flush_m_stall", 32'(lat3Stall), 32'b111);
      applyStimulus(0, 0, 0, 0, 1, 0, 2'b01, 0);
      checkOutput("flush_n_stall", 32'(lat3Stall), 32'b000);
      checkOutput("flush_count",   32'(lat3Count), 32'd9);

      // Reset while r1 is pending at 2: consumer right after reset is not stalled.
      applyStimulus(0, 1, 0, 1, 0, 0, 2'b00, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 2'b01, 0);
      checkOutput("midrst_stall",   32'(lat3Stall),   32'b000);
      checkOutput("midrst_pending", 32'(lat3Pending), 32'd0);
      checkOutput("midrst_count",   32'(lat3Count),   32'd0);

      // CNT_W=4: hold an EX-stage hazard for 20 cycles; counter stops at 15.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1, 0, 3, 3, 0, 2'b01, 0);
         if (i == 14) checkOutput("sat_count14", 32'(lat1Count), 32'd14);
         if (i == 15) checkOutput("sat_count15", 32'(lat1Count), 32'd15);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      checkOutput("sat_final", 32'(lat1Count), 32'd15);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      checkOutput("sat_hold",  32'(lat1Count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
